// File: rtl/alu_muldiv_seq_pkg.sv
// Shared ALU control codes, muldiv op encodings and sequencer states.
package alu_muldiv_seq_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_ORR  = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_ADDU = 4'b1010;
  localparam logic [3:0] ALU_SUBU = 4'b1011;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REMU = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL_IT  = 3'd1,
    ST_DIV_CMP = 3'd2,
    ST_DIV_SUB = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL/DIVU/REMU sequencer that borrows the core ALU,
// issuing one ALU operation per cycle.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for a request, start_ready high
// ST_MUL_IT  | shift-add iteration, one ADD per cycle
// ST_DIV_CMP | shift remainder in, SLTU against divisor
// ST_DIV_SUB | conditional SUBU, sets quotient bit
// ST_DONE    | result_valid high until result_ready
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_control,
  output logic [4:0]       alu_shamt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;       // multiplicand / quotient
  logic [WIDTH-1:0] b_q, b_d;       // multiplier / divisor
  logic [WIDTH-1:0] acc_q, acc_d;   // product accumulator / remainder
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, lt_q, lt_d;
  logic             start_ready_q, start_ready_d;
  logic             result_valid_q, result_valid_d;
  logic [WIDTH-1:0] r_sh, q_next, r_next;

  assign r_sh = {acc_q[WIDTH-2:0], a_q[WIDTH-1]};

  always_comb begin
    alu_control = ALU_ADD;
    alu_a       = '0;
    alu_b       = '0;
    case (state_q)
      ST_MUL_IT: begin
        alu_a = acc_q;
        alu_b = b_q[0] ? a_q : '0;
      end
      ST_DIV_CMP: begin
        alu_control = ALU_SLTU;
        alu_a       = r_sh;
        alu_b       = b_q;
      end
      ST_DIV_SUB: begin
        alu_control = ALU_SUBU;
        alu_a       = acc_q;
        alu_b       = b_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    lt_d     = lt_q;
    q_next   = a_q;
    r_next   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          op_d  = op;
          a_d   = operand_a;
          b_d   = operand_b;
          acc_d = '0;
          cnt_d = '0;
          c_d   = 1'b0;
          lt_d  = 1'b0;
          case (op)
            OP_MUL:  state_d = ST_MUL_IT;
            OP_DIVU: begin
              if (operand_b == '0) begin
                result_d = '1;
                state_d  = ST_DONE;
              end else begin
                state_d = ST_DIV_CMP;
              end
            end
            OP_REMU: begin
              if (operand_b == '0) begin
                result_d = operand_a;
                state_d  = ST_DONE;
              end else begin
                state_d = ST_DIV_CMP;
              end
            end
            default: begin
              result_d = '0;
              state_d  = ST_DONE;
            end
          endcase
        end
      end
      ST_MUL_IT: begin
        acc_d = alu_out;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          result_d = alu_out;
          state_d  = ST_DONE;
        end
      end
      ST_DIV_CMP: begin
        acc_d   = r_sh;
        c_d     = acc_q[WIDTH-1];
        a_d     = a_q << 1;
        lt_d    = alu_out[0];
        state_d = ST_DIV_SUB;
      end
      ST_DIV_SUB: begin
        // A set c means the true remainder exceeds WIDTH bits, so it is >= divisor.
        if (c_q || !lt_q) begin
          r_next    = alu_out;
          q_next[0] = 1'b1;
        end
        acc_d = r_next;
        a_d   = q_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          result_d = (op_q == OP_DIVU) ? q_next : r_next;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_DIV_CMP;
        end
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    start_ready_d  = (state_d == ST_IDLE);
    result_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      op_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      cnt_q          <= '0;
      c_q            <= 1'b0;
      lt_q           <= 1'b0;
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      a_q            <= a_d;
      b_q            <= b_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      cnt_q          <= cnt_d;
      c_q            <= c_d;
      lt_q           <= lt_d;
      start_ready_q  <= start_ready_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign start_ready  = start_ready_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign alu_shamt    = 5'd0;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq with a behavioural ALU attached to its alu_* port.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_valid, start_ready;
  logic [1:0]   op;
  logic [W-1:0] operand_a, operand_b;
  logic         result_valid, result_ready;
  logic [W-1:0] result;
  logic [3:0]   alu_control;
  logic [4:0]   alu_shamt;
  logic [W-1:0] alu_a, alu_b, alu_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .operand_a(operand_a), .operand_b(operand_b),
    .result_valid(result_valid), .result_ready(result_ready), .result(result),
    .alu_control(alu_control), .alu_shamt(alu_shamt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  // Processor ALU stand-in, combinational.
  always_comb begin
    alu_out = '0;
    case (alu_control)
      ALU_ADD, ALU_ADDU: alu_out = alu_a + alu_b;
      ALU_SUB, ALU_SUBU: alu_out = alu_a - alu_b;
      ALU_SLT:  alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_out = {31'b0, alu_a < alu_b};
      ALU_XOR:  alu_out = alu_a ^ alu_b;
      ALU_ORR:  alu_out = alu_a | alu_b;
      ALU_AND:  alu_out = alu_a & alu_b;
      ALU_SLL:  alu_out = alu_a << alu_shamt;
      ALU_SRL:  alu_out = alu_a >> alu_shamt;
      ALU_SRA:  alu_out = $unsigned($signed(alu_a) >>> alu_shamt);
      default:  alu_out = '0;
    endcase
  end

  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a, b);
    logic [63:0] p;
    case (o)
      2'b00: begin p = 64'(a) * 64'(b); return p[W-1:0]; end
      2'b01: return (b == 0) ? {W{1'b1}} : a / b;
      2'b10: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  // Edges after the acceptance edge until result_valid is seen high.
  function automatic int ref_lat(input logic [1:0] o, input logic [W-1:0] b);
    if (o == 2'b00) return W;
    if ((o == 2'b01 || o == 2'b10) && b != 0) return 2 * W;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a, b,
                        input int hold, output logic [W-1:0] res, output int lat);
    int k, ctl_err, hold_err;
    logic [3:0] exp_ctl;
    @(negedge clk);
    chk({tag, " start_ready"}, W'(start_ready), 1);
    start_valid = 1'b1; op = o; operand_a = a; operand_b = b; result_ready = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0; op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
    @(negedge clk);
    k = 0; ctl_err = 0;
    while (!result_valid && k < 300) begin
      if (o == 2'b00) exp_ctl = ALU_ADD;
      else exp_ctl = (k % 2 == 0) ? ALU_SLTU : ALU_SUBU;
      if (alu_control !== exp_ctl || alu_shamt !== 5'd0) ctl_err++;
      @(negedge clk);
      k++;
    end
    lat = k;
    res = result;
    chk({tag, " alu_control errs"}, W'(ctl_err), 0);
    hold_err = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (result !== res || start_ready !== 1'b0 || result_valid !== 1'b1 ||
          alu_control !== ALU_ADD || alu_a !== 0 || alu_b !== 0) hold_err++;
    end
    if (hold > 0) chk({tag, " hold errs"}, W'(hold_err), 0);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    @(negedge clk);
    chk({tag, " idle after"}, {30'b0, start_ready, result_valid}, 32'b10);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, exp;
    int           lat;
  } vec_t;

  vec_t tv[12];

  initial begin
    logic [W-1:0] res, a, b;
    logic [1:0] o;
    int lat, busy_err;

    tv[0]  = '{2'b00, 32'd7,          32'd6,          32'd42,         32};
    tv[1]  = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   32};
    tv[2]  = '{2'b00, 32'h12345678,   32'd0,          32'd0,          32};
    tv[3]  = '{2'b01, 32'd100,        32'd7,          32'd14,         64};
    tv[4]  = '{2'b10, 32'd100,        32'd7,          32'd2,          64};
    tv[5]  = '{2'b01, 32'hFFFFFFFF,   32'h80000000,   32'd1,          64};
    tv[6]  = '{2'b10, 32'hFFFFFFFF,   32'h80000000,   32'h7FFFFFFF,   64};
    tv[7]  = '{2'b01, 32'd5,          32'd0,          32'hFFFFFFFF,   0};
    tv[8]  = '{2'b10, 32'd123,        32'd0,          32'd123,        0};
    tv[9]  = '{2'b11, 32'hAB,         32'hCD,         32'd0,          0};
    tv[10] = '{2'b01, 32'd7,          32'd100,        32'd0,          64};
    tv[11] = '{2'b10, 32'd7,          32'd100,        32'd7,          64};

    reset = 1'b1; start_valid = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset start_ready", W'(start_ready), 1);
    chk("reset result_valid", W'(result_valid), 0);
    chk("reset result", result, 0);
    chk("reset alu_control", W'(alu_control), 0);
    chk("reset alu_a", alu_a, 0);
    chk("reset alu_b", alu_b, 0);

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, 0, res, lat);
      chk($sformatf("vec%0d result", i), res, tv[i].exp);
      chk($sformatf("vec%0d latency", i), W'(lat), W'(tv[i].lat));
    end

    run_op("hold", 2'b00, 32'hDEAD, 32'hBEEF, 5, res, lat);
    chk("hold result", res, 32'hDEAD * 32'hBEEF);

    // Abort a DIVU around iteration 10 with reset.
    @(negedge clk);
    start_valid = 1'b1; op = 2'b01; operand_a = 32'd1000; operand_b = 32'd3;
    @(posedge clk); #1 start_valid = 1'b0;
    busy_err = 0;
    repeat (20) begin
      @(negedge clk);
      if (result_valid) busy_err++;
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort start_ready", W'(start_ready), 1);
    chk("abort alu_control", W'(alu_control), 0);
    repeat (100) begin
      if (result_valid) busy_err++;
      @(negedge clk);
    end
    chk("abort no result_valid", W'(busy_err), 0);
    run_op("after abort", 2'b00, 32'd3, 32'd3, 0, res, lat);
    chk("after abort result", res, 32'd9);
    chk("after abort latency", W'(lat), 32);

    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), o, a, b, 0, res, lat);
      chk($sformatf("rnd%0d op%0d %h,%h result", i, o, a, b), res, ref_result(o, a, b));
      chk($sformatf("rnd%0d latency", i), W'(lat), W'(ref_lat(o, b)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
